reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
- 32-entry register file for the datapath, with two read ports and one write port.
- It sits directly upstream of the 32-bit 32x1 read-select mux tree and the operand-select 2x1 muxes, and supplies the register operands they select among.
- Reads are command-strobed and registered, with a one-cycle latency.
- Register 0 is hardwired to zero when ZERO_REG=1.

Parameters:
DATA_WIDTH, 32, width of each register and data port
ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH
ZERO_REG, 1, 1: entry 0 reads as 0 and ignores writes; 0: entry 0 is an ordinary register

Ports:
CLK  input  1  clock, rising-edge active
RST  input  1  synchronous, active-high reset
READ  input  1  read command strobe, sampled on rising CLK
WRITE  input  1  write command strobe, sampled on rising CLK
ADDR_R1  input  ADDR_WIDTH  read port 1 address
ADDR_R2  input  ADDR_WIDTH  read port 2 address
ADDR_W  input  ADDR_WIDTH  write address
DATA_W  input  DATA_WIDTH  write data
DATA_R1  output  DATA_WIDTH  read port 1 data, registered
DATA_R2  output  DATA_WIDTH  read port 2 data, registered
RD_VALID  output  1  high for exactly one cycle after each accepted READ

Behaviour:
- Clocking: one clock, CLK. RST is synchronous and active-high, sampled only on the rising CLK edge.
- Reset:
  - While RST=1 at an edge, every storage entry clears to 0.
  - DATA_R1, DATA_R2 and RD_VALID clear to 0.
  - READ and WRITE are ignored that cycle.
  - Asserting RST mid-operation cancels any read in flight: RD_VALID is 0 in the following cycle.
- Write:
  - At an edge with WRITE=1 and RST=0, mem[ADDR_W] <= DATA_W.
  - When ZERO_REG=1 and ADDR_W=0, the write is discarded and entry 0 stays 0.
- Read:
  - At an edge with READ=1 and RST=0, DATA_R1 <= mem[ADDR_R1] and DATA_R2 <= mem[ADDR_R2].
  - RD_VALID <= 1 at that edge. Latency is 1 cycle: the data is visible in the cycle after READ is sampled.
  - When READ=0, RD_VALID <= 0 and DATA_R1/DATA_R2 hold their last values. They do not track address changes.
- Simultaneous READ and WRITE (write-first bypass):
  - If ADDR_R1 == ADDR_W (or ADDR_R2 == ADDR_W) and the write is not discarded, the corresponding output captures DATA_W, not the old contents.
  - Both ports bypass independently; they may both match the same write.
  - With ZERO_REG=1 and ADDR_W=0, no bypass occurs and reads of address 0 return 0.
- Entry 0: with ZERO_REG=1, reads of address 0 always return 0, regardless of any write or bypass.
- Address range: every ADDR_WIDTH-bit address is valid. No wrap or out-of-range cases exist.
- Back-to-back operation:
  - READ may be held high on consecutive cycles. Each cycle produces a new registered sample, and RD_VALID stays high.
  - Consecutive WRITEs to the same address: the last one wins.
- No combinational path exists from any input to any output.
- Storage: a register array of 2**ADDR_WIDTH entries of DATA_WIDTH bits, with no initialization other than reset.

Test Plan:
- Reset check:
  - Stimulus: RST=1 for 2 cycles, then READ with ADDR_R1=5, ADDR_R2=31.
  - Required: DATA_R1=0, DATA_R2=0, RD_VALID=1 one cycle after READ; RD_VALID=0 during reset and the cycle after.
- Write-then-read:
  - Stimulus: WRITE ADDR_W=7 DATA_W=32'hDEADBEEF; next cycle READ ADDR_R1=7, ADDR_R2=7.
  - Required: both outputs read 32'hDEADBEEF one cycle later with RD_VALID=1.
- Zero register:
  - Stimulus: WRITE ADDR_W=0 DATA_W=32'hFFFFFFFF, then READ ADDR_R1=0.
  - Required: DATA_R1=0. Same write and read in a single cycle also returns 0 (no bypass).
- Bypass:
  - Stimulus: preload mem[3]=32'h11111111; in one cycle assert WRITE ADDR_W=3 DATA_W=32'h22222222 together with READ ADDR_R1=3, ADDR_R2=4 (mem[4]=32'hA5A5A5A5).
  - Required: DATA_R1=32'h22222222, DATA_R2=32'hA5A5A5A5.
- Hold and valid:
  - Stimulus: READ returns mem[9]=32'h12345678; then READ=0 for 3 cycles while ADDR_R1 changes and mem[9] is rewritten to 32'h0.
  - Required: DATA_R1 stays 32'h12345678, RD_VALID=0 for those 3 cycles.
- Reset mid-stream:
  - Stimulus: fill entries 1..31 with value=index; assert RST in the same cycle as a READ.
  - Required: next cycle RD_VALID=0 and outputs 0; subsequent reads of every address return 0.

Source files
------------

// File: rtl/reg_file_2r1w_if.sv
// -----------------------------------------------------------------------------
// reg_file_2r1w_if
// Bus bundle for the 2-read / 1-write register file.
//
// Signals:
//   READ     read command strobe (master -> slave)
//   WRITE    write command strobe (master -> slave)
//   ADDR_R1  read port 1 address (master -> slave)
//   ADDR_R2  read port 2 address (master -> slave)
//   ADDR_W   write address (master -> slave)
//   DATA_W   write data (master -> slave)
//   DATA_R1  registered read port 1 data (slave -> master)
//   DATA_R2  registered read port 2 data (slave -> master)
//   RD_VALID one-cycle pulse after each accepted READ (slave -> master)
//
// Modports: master drives commands, slave (the register file) returns data.
// -----------------------------------------------------------------------------
interface reg_file_2r1w_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  READ;
  logic                  WRITE;
  logic [ADDR_WIDTH-1:0] ADDR_R1;
  logic [ADDR_WIDTH-1:0] ADDR_R2;
  logic [ADDR_WIDTH-1:0] ADDR_W;
  logic [DATA_WIDTH-1:0] DATA_W;
  logic [DATA_WIDTH-1:0] DATA_R1;
  logic [DATA_WIDTH-1:0] DATA_R2;
  logic                  RD_VALID;

  modport master (
    output READ, WRITE, ADDR_R1, ADDR_R2, ADDR_W, DATA_W,
    input  DATA_R1, DATA_R2, RD_VALID
  );

  modport slave (
    input  READ, WRITE, ADDR_R1, ADDR_R2, ADDR_W, DATA_W,
    output DATA_R1, DATA_R2, RD_VALID
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// -----------------------------------------------------------------------------
// reg_file_2r1w
// 2**ADDR_WIDTH-entry register file with two command-strobed, registered read
// ports (1-cycle latency) and one write port. A read in the same cycle as a
// write to the same address returns the new data (write-first). With
// ZERO_REG=1, entry 0 ignores writes and always reads as zero.
//
// Ports:
//   CLK  rising-edge clock
//   RST  synchronous active-high reset: clears storage, read data and RD_VALID
//   bus  reg_file_2r1w_if.slave: READ/WRITE strobes, ADDR_R1/ADDR_R2/ADDR_W,
//        DATA_W in; DATA_R1/DATA_R2/RD_VALID out (all registered)
// -----------------------------------------------------------------------------
module reg_file_2r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  reg_file_2r1w_if.slave       bus
);

  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam int NUM_RD   = 2;
  localparam bit ZERO_EN  = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_addr [NUM_RD];
  logic [DATA_WIDTH-1:0] rd_data [NUM_RD];
  logic                  rd_valid_reg;
  logic                  write_ok;

  // A write to entry 0 is dropped entirely when it is hardwired; this same
  // qualifier gates the bypass so a dropped write can never leak to a reader.
  assign write_ok = bus.WRITE && !(ZERO_EN && (bus.ADDR_W == '0));

  assign rd_addr[0] = bus.ADDR_R1;
  assign rd_addr[1] = bus.ADDR_R2;

  // Storage: reset clears every entry, so this is a register array rather
  // than a RAM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (write_ok) begin
      mem_reg[bus.ADDR_W] <= bus.DATA_W;
    end
  end

  // One identical registered read port per address; outputs hold while
  // READ is low.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : gen_rd_port
      logic [DATA_WIDTH-1:0] data_r_next;
      logic [DATA_WIDTH-1:0] data_r_reg;

      always_comb begin
        data_r_next = mem_reg[rd_addr[gi]];
        if (write_ok && (rd_addr[gi] == bus.ADDR_W)) begin
          data_r_next = bus.DATA_W;
        end
        // Entry 0 is forced on the read side too, so it reads as zero even
        // before the first reset has cleared the storage.
        if (ZERO_EN && (rd_addr[gi] == '0)) begin
          data_r_next = '0;
        end
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          data_r_reg <= '0;
        end else if (bus.READ) begin
          data_r_reg <= data_r_next;
        end
      end

      assign rd_data[gi] = data_r_reg;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= bus.READ;
    end
  end

  assign bus.DATA_R1  = rd_data[0];
  assign bus.DATA_R2  = rd_data[1];
  assign bus.RD_VALID = rd_valid_reg;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// -----------------------------------------------------------------------------
// tb_reg_file_2r1w
// Self-checking bench for reg_file_2r1w: directed scenarios with literal
// expectations plus a randomized phase, all checked each cycle against a
// behavioural model of the register file.
// -----------------------------------------------------------------------------
module tb_reg_file_2r1w;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst;

  reg_file_2r1w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  reg_file_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_count  = 0;
  int total_count = 0;
  bit done        = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total_count++;
    if (act === req) begin
      pass_count++;
    end else begin
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_r1, exp_r2;
  logic          exp_valid;
  bit            model_known = 1'b0;

  // Value a read of address a returns given the inputs of this edge:
  // register 0 is always zero; otherwise a same-cycle write wins.
  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (bus_if.WRITE && (bus_if.ADDR_W == a)) return bus_if.DATA_W;
    return model_mem[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] <= '0;
      exp_r1      <= '0;
      exp_r2      <= '0;
      exp_valid   <= 1'b0;
      model_known <= 1'b1;
    end else begin
      if (bus_if.READ) begin
        exp_r1 <= model_read(bus_if.ADDR_R1);
        exp_r2 <= model_read(bus_if.ADDR_R2);
      end
      exp_valid <= bus_if.READ;
      if (bus_if.WRITE && bus_if.ADDR_W != 0) model_mem[bus_if.ADDR_W] <= bus_if.DATA_W;
    end
  end

  // Compare process: outputs are meaningful on every cycle after a reset.
  always @(negedge clk) begin
    if (model_known && !done) begin
      check("cyc_valid", {31'b0, bus_if.RD_VALID}, {31'b0, exp_valid});
      check("cyc_r1", bus_if.DATA_R1, exp_r1);
      check("cyc_r2", bus_if.DATA_R2, exp_r2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.READ  = 1'b0;
    bus_if.WRITE = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_if.WRITE  = 1'b1;
    bus_if.ADDR_W = a;
    bus_if.DATA_W = d;
    tick();
    bus_if.WRITE  = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus_if.READ    = 1'b0;
    bus_if.WRITE   = 1'b0;
    bus_if.ADDR_R1 = '0;
    bus_if.ADDR_R2 = '0;
    bus_if.ADDR_W  = '0;
    bus_if.DATA_W  = '0;

    // Reset check
    tick();
    tick();
    check("rst_valid", {31'b0, bus_if.RD_VALID}, 32'd0);
    check("rst_r1", bus_if.DATA_R1, 32'd0);
    rst = 1'b0;
    bus_if.READ = 1'b1; bus_if.ADDR_R1 = 5'd5; bus_if.ADDR_R2 = 5'd31;
    tick();
    idle();
    check("rst_read_valid", {31'b0, bus_if.RD_VALID}, 32'd1);
    check("rst_read_r1", bus_if.DATA_R1, 32'd0);
    check("rst_read_r2", bus_if.DATA_R2, 32'd0);

    // Write-then-read
    do_write(5'd7, 32'hDEADBEEF);
    bus_if.READ = 1'b1; bus_if.ADDR_R1 = 5'd7; bus_if.ADDR_R2 = 5'd7;
    tick();
    idle();
    check("wr_rd_r1", bus_if.DATA_R1, 32'hDEADBEEF);
    check("wr_rd_r2", bus_if.DATA_R2, 32'hDEADBEEF);
    check("wr_rd_valid", {31'b0, bus_if.RD_VALID}, 32'd1);
    check("wr_rd_model", exp_r1, 32'hDEADBEEF);

    // Zero register: separate cycles, then same cycle
    do_write(5'd0, 32'hFFFFFFFF);
    bus_if.READ = 1'b1; bus_if.ADDR_R1 = 5'd0; bus_if.ADDR_R2 = 5'd7;
    tick();
    idle();
    check("zero_r1", bus_if.DATA_R1, 32'd0);
    bus_if.WRITE = 1'b1; bus_if.ADDR_W = 5'd0; bus_if.DATA_W = 32'hFFFFFFFF;
    bus_if.READ  = 1'b1; bus_if.ADDR_R1 = 5'd0; bus_if.ADDR_R2 = 5'd0;
    tick();
    idle();
    check("zero_byp_r1", bus_if.DATA_R1, 32'd0);
    check("zero_byp_r2", bus_if.DATA_R2, 32'd0);

    // Bypass
    do_write(5'd3, 32'h11111111);
    do_write(5'd4, 32'hA5A5A5A5);
    bus_if.WRITE = 1'b1; bus_if.ADDR_W = 5'd3; bus_if.DATA_W = 32'h22222222;
    bus_if.READ  = 1'b1; bus_if.ADDR_R1 = 5'd3; bus_if.ADDR_R2 = 5'd4;
    tick();
    idle();
    check("byp_r1", bus_if.DATA_R1, 32'h22222222);
    check("byp_r2", bus_if.DATA_R2, 32'hA5A5A5A5);
    check("byp_model", exp_r1, 32'h22222222);
    // Both ports hitting the same write
    bus_if.WRITE = 1'b1; bus_if.ADDR_W = 5'd12; bus_if.DATA_W = 32'h0BADF00D;
    bus_if.READ  = 1'b1; bus_if.ADDR_R1 = 5'd12; bus_if.ADDR_R2 = 5'd12;
    tick();
    idle();
    check("byp_both_r1", bus_if.DATA_R1, 32'h0BADF00D);
    check("byp_both_r2", bus_if.DATA_R2, 32'h0BADF00D);

    // Hold and valid
    do_write(5'd9, 32'h12345678);
    bus_if.READ = 1'b1; bus_if.ADDR_R1 = 5'd9; bus_if.ADDR_R2 = 5'd3;
    tick();
    idle();
    check("hold_first", bus_if.DATA_R1, 32'h12345678);
    for (int k = 0; k < 3; k++) begin
      bus_if.ADDR_R1 = 5'(k + 1);
      if (k == 0) begin
        bus_if.WRITE = 1'b1; bus_if.ADDR_W = 5'd9; bus_if.DATA_W = 32'h0;
      end
      tick();
      idle();
      check("hold_r1", bus_if.DATA_R1, 32'h12345678);
      check("hold_valid", {31'b0, bus_if.RD_VALID}, 32'd0);
    end

    // Randomized traffic with occasional resets
    for (int n = 0; n < 2000; n++) begin
      rst            = ($urandom_range(0, 63) == 0);
      bus_if.READ    = 1'($urandom);
      bus_if.WRITE   = 1'($urandom);
      bus_if.ADDR_R1 = 5'($urandom);
      bus_if.ADDR_R2 = ($urandom_range(0, 3) == 0) ? bus_if.ADDR_W : 5'($urandom);
      bus_if.ADDR_W  = ($urandom_range(0, 3) == 0) ? bus_if.ADDR_R1 : 5'($urandom);
      bus_if.DATA_W  = $urandom;
      tick();
    end
    rst = 1'b0;
    idle();
    tick();

    // Reset mid-stream
    for (int a = 1; a < DEPTH; a++) do_write(5'(a), 32'(a));
    bus_if.READ = 1'b1; bus_if.ADDR_R1 = 5'd30; bus_if.ADDR_R2 = 5'd31;
    tick();
    check("pre_rst_r2", bus_if.DATA_R2, 32'd31);
    rst = 1'b1;
    bus_if.ADDR_R1 = 5'd5; bus_if.ADDR_R2 = 5'd6;
    tick();
    rst = 1'b0;
    idle();
    check("midrst_valid", {31'b0, bus_if.RD_VALID}, 32'd0);
    check("midrst_r1", bus_if.DATA_R1, 32'd0);
    check("midrst_r2", bus_if.DATA_R2, 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      bus_if.READ = 1'b1; bus_if.ADDR_R1 = 5'(a); bus_if.ADDR_R2 = 5'(DEPTH - 1 - a);
      tick();
      check("postrst_r1", bus_if.DATA_R1, 32'd0);
      check("postrst_r2", bus_if.DATA_R2, 32'd0);
      check("postrst_valid", {31'b0, bus_if.RD_VALID}, 32'd1);
    end
    idle();
    tick();

    done = 1'b1;
    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
